// File: rtl/lsu.sv
// lsu: load/store unit that checks alignment, issues one word-aligned bus
// transaction per request and returns extended load data or store completion.
module lsu (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_reqValid,
    input  logic        i_is_store,
    input  logic [1:0]  i_size,
    input  logic        i_is_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_respValid,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_mem_reqValid,
    input  logic        i_mem_reqReady,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_respValid,
    input  logic [31:0] i_mem_rdata
);
    typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_RESP} state_t;
    state_t      r_state, w_next;
    logic        r_is_store, r_is_unsigned, r_err;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic        w_mis, w_sign;
    logic [31:0] w_shifted, w_load;

    assign w_mis = (i_size == 2'b11) || (i_size == 2'b01 && i_addr[0]) ||
                   (i_size == 2'b10 && i_addr[1:0] != 2'b00);

    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) r_state <= LSU_IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            LSU_IDLE: if (i_reqValid) w_next = w_mis ? LSU_RESP : LSU_REQ;
            LSU_REQ:  if (i_mem_reqReady) w_next = LSU_WAIT;
            LSU_WAIT: if (i_mem_respValid) w_next = LSU_RESP;
            default:  w_next = LSU_IDLE;
        endcase
    end

    assign w_shifted = i_mem_rdata >> {r_addr[1:0], 3'b000};
    assign w_sign    = ~r_is_unsigned & (r_size == 2'b00 ? w_shifted[7] : w_shifted[15]);
    assign w_load    = r_size == 2'b00 ? {{24{w_sign}}, w_shifted[7:0]} :
                       r_size == 2'b01 ? {{16{w_sign}}, w_shifted[15:0]} : w_shifted;

    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) begin
            r_is_store    <= 1'b0;
            r_is_unsigned <= 1'b0;
            r_size        <= 2'b00;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_err         <= 1'b0;
        end else if (r_state == LSU_IDLE && i_reqValid) begin
            r_is_store    <= i_is_store;
            r_is_unsigned <= i_is_unsigned;
            r_size        <= i_size;
            r_addr        <= i_addr;
            r_wdata       <= i_wdata;
            // error responses are produced straight from idle; good ones update at bus response
            if (w_mis) begin
                r_err   <= 1'b1;
                r_rdata <= '0;
            end
        end else if (r_state == LSU_WAIT && i_mem_respValid) begin
            r_err   <= 1'b0;
            r_rdata <= r_is_store ? 32'd0 : w_load;
        end

    assign o_respValid    = r_state == LSU_RESP;
    assign o_rdata        = r_rdata;
    assign o_err          = r_err;
    assign o_mem_reqValid = r_state == LSU_REQ;
    assign o_mem_wen      = r_is_store;
    assign o_mem_addr     = {r_addr[31:2], 2'b00};
    assign o_mem_wdata    = r_size == 2'b00 ? {4{r_wdata[7:0]}} :
                            r_size == 2'b01 ? {2{r_wdata[15:0]}} : r_wdata;
    assign o_mem_wstrb    = !r_is_store     ? 4'b0000 :
                            r_size == 2'b00 ? 4'b0001 << r_addr[1:0] :
                            r_size == 2'b01 ? 4'b0011 << {r_addr[1], 1'b0} : 4'b1111;
endmodule
